// File: rtl/chained_hasher_pkg.sv
// Shared types and defaults for the chained block hasher.
// Holds the FSM state encoding, default round constants and a length-width helper.
// No logic of its own; imported by the top and the round datapath.
package chained_hasher_pkg;

  // Controller states: waiting for a block, iterating rounds, holding a digest
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Default seed for unchained blocks and the additive constant (golden ratio)
  localparam logic [31:0] DEF_SEED        = 32'h0000_0000;
  localparam logic [31:0] DEF_ROUND_CONST = 32'h9E37_79B9;
  localparam int          DEF_ROT         = 5;

  // Width of a byte-count field able to hold 0..data_bytes inclusive
  function automatic int len_w(input int data_bytes);
    return $clog2(data_bytes + 1);
  endfunction

endpackage

// File: rtl/chained_hasher_hash_round.sv
// One rotate-xor-add round: o_h = rotl(i_h ^ i_w, ROT) + ROUND_CONST.
// Purely combinational, zero latency.
// No handshake; the caller registers the result.
module hash_round #(
  parameter int                    HASH_WIDTH  = 32,
  parameter int                    ROT         = 5,
  parameter logic [HASH_WIDTH-1:0] ROUND_CONST = HASH_WIDTH'(32'h9E37_79B9)
) (
  input  logic [HASH_WIDTH-1:0] i_h,
  input  logic [HASH_WIDTH-1:0] i_w,
  output logic [HASH_WIDTH-1:0] o_h
);

  logic [HASH_WIDTH-1:0] w_mix;
  logic [HASH_WIDTH-1:0] w_rot;

  // Mix in the word, rotate left (ROT=0 degenerates cleanly since the
  // right shift by HASH_WIDTH yields zero), then add the round constant
  always_comb begin
    w_mix = i_h ^ i_w;
    w_rot = (w_mix << ROT) | (w_mix >> (HASH_WIDTH - ROT));
    o_h   = w_rot + ROUND_CONST;
  end

endmodule

// File: rtl/chained_hasher.sv
// Multi-round block hasher with optional chaining of the previous digest as seed.
// Latency: digest valid exactly ROUNDS cycles after the accept edge; one block per ROUNDS+2 cycles.
// Backpressure: in_ready only in IDLE; digest and out_valid hold while out_ready is low.
module chained_hasher
  import chained_hasher_pkg::*;
#(
  parameter int                    DATA_BYTES  = 8,
  parameter int                    HASH_WIDTH  = 32,
  parameter int                    ROUNDS      = 4,
  parameter int                    ROT         = DEF_ROT,
  parameter logic [HASH_WIDTH-1:0] SEED        = HASH_WIDTH'(DEF_SEED),
  parameter logic [HASH_WIDTH-1:0] ROUND_CONST = HASH_WIDTH'(DEF_ROUND_CONST)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_BYTES*8-1:0]        data,
  input  logic [len_w(DATA_BYTES)-1:0]   data_len,
  input  logic                           in_chain,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [HASH_WIDTH-1:0]          hash,
  output logic                           busy
);

  localparam int LW  = len_w(DATA_BYTES);
  localparam int NW  = DATA_BYTES * 8 / HASH_WIDTH;
  localparam int CW  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  // Registered state and outputs
  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [DATA_BYTES*8-1:0] r_blk;
  logic [HASH_WIDTH-1:0]   r_h;
  logic [HASH_WIDTH-1:0]   r_chain;
  logic [HASH_WIDTH-1:0]   r_hash;
  logic                    r_out_valid;
  logic                    r_in_ready;
  logic                    r_busy;

  // Combinational datapath
  logic [LW-1:0]           w_len_eff;
  logic [DATA_BYTES*8-1:0] w_masked;
  logic [HASH_WIDTH-1:0]   w_h0;
  logic [HASH_WIDTH-1:0]   w_word;
  logic [HASH_WIDTH-1:0]   w_round;

  // Saturate the byte count, zero bytes past it, and form the seeded start state.
  // The effective length only feeds h0, so it is folded in at accept time
  // rather than held in its own register.
  always_comb begin
    w_len_eff = (data_len > LW'(DATA_BYTES)) ? LW'(DATA_BYTES) : data_len;
    w_masked  = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (LW'(i) < w_len_eff) begin
        w_masked[8*i +: 8] = data[8*i +: 8];
      end
    end
    w_h0 = (in_chain ? r_chain : SEED) ^ HASH_WIDTH'(w_len_eff);
  end

  // Pick word (round index mod NW) of the latched block for the current round
  always_comb begin
    w_word = '0;
    for (int j = 0; j < NW; j++) begin
      if ((int'(r_cnt) % NW) == j) begin
        w_word = r_blk[j*HASH_WIDTH +: HASH_WIDTH];
      end
    end
  end

  hash_round #(
    .HASH_WIDTH  (HASH_WIDTH),
    .ROT         (ROT),
    .ROUND_CONST (ROUND_CONST)
  ) u_round (
    .i_h (r_h),
    .i_w (w_word),
    .o_h (w_round)
  );

  // Block controller: accept in IDLE, one round per cycle, hold digest until taken
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_blk       <= '0;
      r_h         <= '0;
      r_chain     <= SEED;
      r_hash      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_blk      <= w_masked;
            r_h        <= w_h0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ROUND;
          end
        end
        ROUND: begin
          r_h <= w_round;
          if (r_cnt == CW'(ROUNDS - 1)) begin
            r_hash      <= w_round;
            r_chain     <= w_round;
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          // No accept on this edge: in_ready rises only once back in IDLE
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign hash      = r_hash;
  assign busy      = r_busy;

endmodule

// File: doc/chained_hasher.md
Name: chained_hasher

Overview:
Sequential, parameterised successor to the combinational hasher. It accepts a message block of up to DATA_BYTES bytes plus a byte length over a valid/ready handshake. It runs ROUNDS iterations of a rotate-xor-add round function, one round per clock, and presents a HASH_WIDTH-bit digest on an output valid/ready handshake. An optional chain mode seeds each block from the previous digest, so multi-block messages can be hashed.

Parameters:
DATA_BYTES, 8, bytes per input block; DATA_BYTES*8 must be a multiple of HASH_WIDTH
HASH_WIDTH, 32, digest width and round word width
ROUNDS, 4, rounds per block; must be >= 1
ROT, 5, left-rotate distance per round; must be < HASH_WIDTH
SEED, 32'h0000_0000, initial state for unchained blocks, HASH_WIDTH bits
ROUND_CONST, 32'h9E37_79B9, additive round constant, HASH_WIDTH bits

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  input block offered
in_ready  out  1  block accepted when in_valid && in_ready
data  in  DATA_BYTES*8  block; byte i = data[8i+7:8i]
data_len  in  $clog2(DATA_BYTES+1)  valid byte count, 0..DATA_BYTES
in_chain  in  1  1 = seed from previous digest instead of SEED
out_valid  out  1  digest available
out_ready  in  1  digest consumed when out_valid && out_ready
hash  out  HASH_WIDTH  digest
busy  out  1  high in ROUND and DONE

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE; out_valid=0, hash=0, busy=0, in_ready=1.
  - Round counter=0; chain register=SEED.
  - Reset asserted in any state, including mid-ROUND, aborts the current block. No digest is produced.
- Length: len_eff = min(data_len, DATA_BYTES).
- Masking: byte i of the block is kept if i < len_eff, otherwise zeroed. This gives masked block m.
- Words: m splits into NW = DATA_BYTES*8/HASH_WIDTH words; w[0] is the least significant.
- Initial state: h0 = (in_chain ? chain_reg : SEED) ^ zero_extend(len_eff).
- Round r (r = 0..ROUNDS-1): h = rotl(h ^ w[r mod NW], ROT) + ROUND_CONST, modulo 2^HASH_WIDTH.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On accept: latch m, len_eff and h0; counter=0; go to ROUND.
- ROUND:
  - in_ready=0.
  - Each cycle apply round[counter] and increment counter.
  - On the cycle counter==ROUNDS-1: write the final h to hash and chain_reg, set out_valid=1, go to DONE.
- DONE:
  - out_valid=1; hash is stable; in_ready=0.
  - On out_ready: out_valid=0, go to IDLE. hash keeps its value until the next digest or reset.
- Timing:
  - Latency: out_valid rises exactly ROUNDS cycles after the accept edge.
  - Throughput: one block per ROUNDS+2 cycles minimum. There is no accept in the same cycle as a DONE handshake.
- Backpressure: in_valid and data are ignored outside IDLE. hash and out_valid hold while out_ready=0.
- Chaining: in_chain=1 on the first block after reset uses chain_reg=SEED.

Decomposition:
- hasher_pkg holds:
  - FSM state enum (IDLE/ROUND/DONE);
  - default SEED, ROUND_CONST and ROT constants;
  - a len-width helper function.
- Sub-module hash_round: combinational, HASH_WIDTH-parameterised. Inputs are h, w and ROT (as a parameter); output is rotl(h^w, ROT)+ROUND_CONST. It is instantiated once and reused each cycle.
- Byte masking and word select stay in the top module.

Test Plan:
1. Reset: after reset, in_ready=1, out_valid=0, busy=0 and hash=0. Assert reset while in ROUND (default parameters) -> IDLE next cycle with no out_valid pulse.
2. Parameters ROUNDS=1, ROT=0, SEED=0. Block data=all ones, data_len=0 -> out_valid one cycle after accept, hash=32'h9E3779B9 (all bytes masked).
3. Same parameters. data=64'hFFFFFFFF_00000001, data_len=4 -> hash=32'h9E3779BE.
4. Parameters ROUNDS=2, ROT=0, SEED=0. data=64'h00000002_00000001, data_len=15 (saturates to 8) -> hash=32'h3C6EF379 two cycles after accept.
5. Chain: after scenario 2, send data_len=0, in_chain=1 -> hash=32'h3C6EF372. Resend the same block with in_chain=0 -> 32'h9E3779B9.
6. Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> hash and out_valid stable, in_ready=0, no extra accept. Then raise out_ready -> IDLE next cycle.
